soc_obi_apb_bridge: RTL

OBI subordinate to APB manager bridge with parametrised width conversion. It splits each wide OBI transfer (default 64-bit) into one or more narrow APB transfers (default 32-bit). It sits between the SoC OBI peripheral crossbar and the APB peripheral cluster, and replaces fixed-width bridging with a ratio-generic, strobe-aware, error-aborting sequencer.

---
 rtl/soc_obi_apb_bridge.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/soc_obi_apb_bridge.sv
// OBI subordinate to APB manager bridge; each wide OBI transfer becomes one APB
// transfer per enabled narrow slice. Optional ACCESS timeout: SOC_OBI_APB_TIMEOUT_EN.
module soc_obi_apb_bridge #(
  parameter int ObiAddrWidth  = 48,
  parameter int ObiDataWidth  = 64,
  parameter int ObiIdWidth    = 4,
  parameter int ApbAddrWidth  = 32,
  parameter int ApbDataWidth  = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      obi_req_i,
  output logic                      obi_gnt_o,
  input  logic [ObiAddrWidth-1:0]   obi_addr_i,
  input  logic                      obi_we_i,
  input  logic [ObiDataWidth/8-1:0] obi_be_i,
  input  logic [ObiDataWidth-1:0]   obi_wdata_i,
  input  logic [ObiIdWidth-1:0]     obi_aid_i,
  output logic                      obi_rvalid_o,
  output logic [ObiDataWidth-1:0]   obi_rdata_o,
  output logic [ObiIdWidth-1:0]     obi_rid_o,
  output logic                      obi_err_o,
  output logic [ApbAddrWidth-1:0]   apb_paddr_o,
  output logic [2:0]                apb_pprot_o,
  output logic                      apb_psel_o,
  output logic                      apb_penable_o,
  output logic                      apb_pwrite_o,
  output logic [ApbDataWidth-1:0]   apb_pwdata_o,
  output logic [ApbDataWidth/8-1:0] apb_pstrb_o,
  input  logic                      apb_pready_i,
  input  logic [ApbDataWidth-1:0]   apb_prdata_i,
  input  logic                      apb_pslverr_i
);

  localparam int R   = ObiDataWidth / ApbDataWidth;
  localparam int SB  = ApbDataWidth / 8;
  localparam int OB  = ObiDataWidth / 8;
  localparam int KW  = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [ApbAddrWidth-1:0]   addr_q;
  logic                      we_q;
  logic [OB-1:0]             be_q;
  logic [ObiDataWidth-1:0]   wdata_q;
  logic [ObiIdWidth-1:0]     aid_q;
  logic [ObiDataWidth-1:0]   rdata_q;
  logic                      err_q;
  logic [KW-1:0]             k_q;

  logic          hs;
  logic          addr_err;
  logic          no_access;
  logic [KW-1:0] first_k;
  logic [KW-1:0] next_k;
  logic          next_ok;
  logic          tmo_hit;
  logic [ApbAddrWidth-1:0] base;

  assign obi_gnt_o = (state_q == IDLE);
  assign hs        = obi_req_i & obi_gnt_o;

  generate
    if (ObiAddrWidth > ApbAddrWidth) begin : g_hi
      assign addr_err = |obi_addr_i[ObiAddrWidth-1:ApbAddrWidth];
    end else begin : g_nohi
      assign addr_err = 1'b0;
    end
  endgenerate

  assign no_access = addr_err | (obi_be_i == '0);

  // Descending scans so the lowest qualifying beat wins.
  always_comb begin
    first_k = '0;
    for (int j = R - 1; j >= 0; j--) begin
      if (|obi_be_i[j*SB +: SB]) first_k = KW'(j);
    end
  end

  always_comb begin
    next_ok = 1'b0;
    next_k  = '0;
    for (int j = R - 1; j >= 0; j--) begin
      if (j > int'(k_q) && (|be_q[j*SB +: SB])) begin
        next_ok = 1'b1;
        next_k  = KW'(j);
      end
    end
  end

`ifdef SOC_OBI_APB_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);
  logic [TW-1:0] tmo_q;

  assign tmo_hit = (state_q == ACCESS) && !apb_pready_i &&
                   (tmo_q == TW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q <= '0;
    end else if (state_q == SETUP) begin
      tmo_q <= '0;
    end else if (state_q == ACCESS && !apb_pready_i) begin
      tmo_q <= tmo_q + TW'(1);
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TimeoutCycles == 0);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (hs) state_d = no_access ? RESP : SETUP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (apb_pready_i) begin
          state_d = (apb_pslverr_i || !next_ok) ? RESP : SETUP;
        end else if (tmo_hit) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      aid_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        addr_q  <= obi_addr_i[ApbAddrWidth-1:0];
        we_q    <= obi_we_i;
        be_q    <= obi_be_i;
        wdata_q <= obi_wdata_i;
        aid_q   <= obi_aid_i;
        rdata_q <= '0;
        err_q   <= addr_err;
        k_q     <= first_k;
      end
      if (state_q == ACCESS && apb_pready_i) begin
        if (!we_q) begin
          rdata_q[int'(k_q)*ApbDataWidth +: ApbDataWidth] <= apb_prdata_i;
        end
        if (apb_pslverr_i) begin
          err_q <= 1'b1;
        end else if (next_ok) begin
          k_q <= next_k;
        end
      end
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  // Beat address is the OBI-aligned base plus the slice offset.
  assign base = addr_q & ~ApbAddrWidth'(OB - 1);

  assign apb_psel_o    = (state_q == SETUP) || (state_q == ACCESS);
  assign apb_penable_o = (state_q == ACCESS);
  assign apb_pprot_o   = 3'b000;
  assign apb_pwrite_o  = we_q;
  assign apb_paddr_o   = base + ApbAddrWidth'(int'(k_q) * SB);
  assign apb_pwdata_o  = wdata_q[int'(k_q)*ApbDataWidth +: ApbDataWidth];
  assign apb_pstrb_o   = we_q ? be_q[int'(k_q)*SB +: SB] : '0;

  assign obi_rvalid_o = (state_q == RESP);
  assign obi_rdata_o  = rdata_q;
  assign obi_rid_o    = aid_q;
  assign obi_err_o    = err_q;

endmodule
